// File: rtl/cam_fill_ctrl_if.sv
// Request/response handshake bundle for cam_fill_ctrl.
// master = requester side, slave = controller side.
interface cam_fill_ctrl_if #(
   parameter int BITS   = 8,
   parameter int TAG_SZ = 8
);
   logic              req_valid;
   logic [TAG_SZ-1:0] req_tag;
   logic              req_ready;
   logic              resp_valid;
   logic              resp_ready;
   logic [BITS-1:0]   resp_data;
   logic              resp_hit;

   modport master (
      output req_valid, req_tag, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_hit
   );

   modport slave (
      input  req_valid, req_tag, resp_ready,
      output req_ready, resp_valid, resp_data, resp_hit
   );
endinterface

// File: rtl/cam_fill_ctrl.sv
// CAM lookup controller: serves hits from the CAM, fills misses from backing memory
// into a round-robin victim slot. Define CAM_FILL_STATS_EN for hit/miss counters.
module cam_fill_ctrl #(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS) - 1
) (
   input  logic                clk,
   input  logic                rst_,
   cam_fill_ctrl_if.slave      bus,
   output logic [TAG_SZ-1:0]   cam_check_tag,
   input  logic                cam_found_it,
   input  logic [BITS-1:0]     cam_data,
   output logic                cam_write_,
   output logic [ADDR_LEFT:0]  cam_w_addr,
   output logic [BITS-1:0]     cam_wdata,
   output logic [TAG_SZ-1:0]   cam_new_tag,
   output logic                cam_new_valid,
   output logic                mem_req,
   output logic [TAG_SZ-1:0]   mem_tag,
   input  logic                mem_ack,
`ifdef CAM_FILL_STATS_EN
   output logic [15:0]         hit_cnt,
   output logic [15:0]         miss_cnt,
`endif
   input  logic [BITS-1:0]     mem_rdata
);

   typedef enum logic [2:0] {IDLE, LOOKUP, MISS, FILL, RESP} state_t;

   localparam logic [ADDR_LEFT:0] LAST_IDX = (ADDR_LEFT + 1)'(WORDS - 1);

   state_t              state_q, state_d;
   logic [TAG_SZ-1:0]   tag_q, tag_d;
   logic [ADDR_LEFT:0]  victim_q, victim_d;
   logic                req_ready_q, req_ready_d;
   logic                resp_valid_q, resp_valid_d;
   logic [BITS-1:0]     resp_data_q, resp_data_d;
   logic                resp_hit_q, resp_hit_d;
   logic                mem_req_q, mem_req_d;
   logic [TAG_SZ-1:0]   mem_tag_q, mem_tag_d;
   logic                cam_write_q, cam_write_d;
   logic [ADDR_LEFT:0]  cam_w_addr_q, cam_w_addr_d;
   logic [BITS-1:0]     cam_wdata_q, cam_wdata_d;
   logic [TAG_SZ-1:0]   cam_new_tag_q, cam_new_tag_d;
   logic                cam_new_valid_q, cam_new_valid_d;
`ifdef CAM_FILL_STATS_EN
   logic [15:0]         hit_cnt_q, hit_cnt_d;
   logic [15:0]         miss_cnt_q, miss_cnt_d;
`endif

   always_comb begin
      state_d         = state_q;
      tag_d           = tag_q;
      victim_d        = victim_q;
      req_ready_d     = req_ready_q;
      resp_valid_d    = resp_valid_q;
      resp_data_d     = resp_data_q;
      resp_hit_d      = resp_hit_q;
      mem_req_d       = mem_req_q;
      mem_tag_d       = mem_tag_q;
      cam_write_d     = cam_write_q;
      cam_w_addr_d    = cam_w_addr_q;
      cam_wdata_d     = cam_wdata_q;
      cam_new_tag_d   = cam_new_tag_q;
      cam_new_valid_d = cam_new_valid_q;
`ifdef CAM_FILL_STATS_EN
      hit_cnt_d       = hit_cnt_q;
      miss_cnt_d      = miss_cnt_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               tag_d       = bus.req_tag;
               req_ready_d = 1'b0;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            if (cam_found_it) begin
               resp_data_d  = cam_data;
               resp_hit_d   = 1'b1;
               resp_valid_d = 1'b1;
               state_d      = RESP;
`ifdef CAM_FILL_STATS_EN
               if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
`endif
            end else begin
               mem_req_d = 1'b1;
               mem_tag_d = tag_q;
               state_d   = MISS;
`ifdef CAM_FILL_STATS_EN
               if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
`endif
            end
         end
         MISS: begin
            // Write fields are registered here so they are all valid for the single FILL cycle.
            if (mem_ack) begin
               mem_req_d       = 1'b0;
               cam_write_d     = 1'b0;
               cam_w_addr_d    = victim_q;
               cam_wdata_d     = mem_rdata;
               cam_new_tag_d   = tag_q;
               cam_new_valid_d = 1'b1;
               state_d         = FILL;
            end
         end
         FILL: begin
            cam_write_d     = 1'b1;
            cam_new_valid_d = 1'b0;
            resp_data_d     = cam_wdata_q;
            resp_hit_d      = 1'b0;
            resp_valid_d    = 1'b1;
            victim_d        = (victim_q == LAST_IDX) ? '0 : victim_q + 1'b1;
            state_d         = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d      = IDLE;
            req_ready_d  = 1'b1;
            resp_valid_d = 1'b0;
            mem_req_d    = 1'b0;
            cam_write_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_) begin
         state_q         <= IDLE;
         tag_q           <= '0;
         victim_q        <= '0;
         req_ready_q     <= 1'b1;
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         resp_hit_q      <= 1'b0;
         mem_req_q       <= 1'b0;
         mem_tag_q       <= '0;
         cam_write_q     <= 1'b1;
         cam_w_addr_q    <= '0;
         cam_wdata_q     <= '0;
         cam_new_tag_q   <= '0;
         cam_new_valid_q <= 1'b0;
`ifdef CAM_FILL_STATS_EN
         hit_cnt_q       <= '0;
         miss_cnt_q      <= '0;
`endif
      end else begin
         state_q         <= state_d;
         tag_q           <= tag_d;
         victim_q        <= victim_d;
         req_ready_q     <= req_ready_d;
         resp_valid_q    <= resp_valid_d;
         resp_data_q     <= resp_data_d;
         resp_hit_q      <= resp_hit_d;
         mem_req_q       <= mem_req_d;
         mem_tag_q       <= mem_tag_d;
         cam_write_q     <= cam_write_d;
         cam_w_addr_q    <= cam_w_addr_d;
         cam_wdata_q     <= cam_wdata_d;
         cam_new_tag_q   <= cam_new_tag_d;
         cam_new_valid_q <= cam_new_valid_d;
`ifdef CAM_FILL_STATS_EN
         hit_cnt_q       <= hit_cnt_d;
         miss_cnt_q      <= miss_cnt_d;
`endif
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_hit   = resp_hit_q;
   assign cam_check_tag  = tag_q;
   assign cam_write_     = cam_write_q;
   assign cam_w_addr     = cam_w_addr_q;
   assign cam_wdata      = cam_wdata_q;
   assign cam_new_tag    = cam_new_tag_q;
   assign cam_new_valid  = cam_new_valid_q;
   assign mem_req        = mem_req_q;
   assign mem_tag        = mem_tag_q;
`ifdef CAM_FILL_STATS_EN
   assign hit_cnt        = hit_cnt_q;
   assign miss_cnt       = miss_cnt_q;
`endif

endmodule

// File: doc/cam_fill_ctrl.md
CAM_FILL_CTRL -- requirements
Module: cam_fill_ctrl

Interface
REQ-001 Parameter WORDS, default 8: number of CAM entries.
REQ-002 Parameter BITS, default 8: data word width.
REQ-003 Parameter TAG_SZ, default 8: tag width.
REQ-004 Parameter ADDR_LEFT, default $clog2(WORDS)-1: MSB of the entry index.
REQ-005 clk  in  1  single system clock; all state changes on its rising edge.
REQ-006 rst_  in  1  reset, synchronous and active-high.
REQ-007 req_valid  in  1  lookup request present.
REQ-008 req_tag  in  TAG_SZ  tag to look up.
REQ-009 req_ready  out  1  controller can accept a request.
REQ-010 resp_valid  out  1  response present.
REQ-011 resp_ready  in  1  consumer accepts the response.
REQ-012 resp_data  out  BITS  returned data.
REQ-013 resp_hit  out  1  1 = served from CAM, 0 = filled from memory.
REQ-014 cam_check_tag  out  TAG_SZ  tag driven to the CAM match port.
REQ-015 cam_found_it, cam_data  in  1, BITS  CAM match result and matched data (combinational from the CAM).
REQ-016 cam_write_  out  1  CAM write strobe, active-low.
REQ-017 cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid  out  ADDR_LEFT+1, BITS, TAG_SZ, 1  CAM write fields.
REQ-018 mem_req, mem_tag  out  1, TAG_SZ  backing-memory fetch request and tag.
REQ-019 mem_ack, mem_rdata  in  1, BITS  fetch completion and returned data, valid together.

Function
REQ-020 The FSM SHALL have states IDLE, LOOKUP, MISS, FILL and RESP.
REQ-021 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge with req_valid=1 and req_ready=1, which registers req_tag and moves the FSM to LOOKUP.
REQ-022 cam_check_tag SHALL always drive the registered tag.
REQ-023 At the LOOKUP edge, if cam_found_it=1, the block SHALL capture cam_data into resp_data, set resp_hit=1 and go to RESP: the hit response is visible 2 cycles after acceptance.
REQ-024 At the LOOKUP edge, if cam_found_it=0, the block SHALL go to MISS.
REQ-025 In MISS, mem_req SHALL be 1 and mem_tag SHALL equal the registered tag, both held stable until mem_ack=1.
REQ-026 mem_ack SHALL be sampled only in MISS and ignored in all other states.
REQ-027 On the MISS edge with mem_ack=1, the block SHALL capture mem_rdata and go to FILL; mem_req SHALL be 0 in the following cycle.
REQ-028 FILL SHALL last exactly 1 cycle and assert the following: cam_write_=0, cam_w_addr=victim pointer, cam_wdata=captured data, cam_new_tag=registered tag, cam_new_valid=1.
REQ-029 cam_write_ SHALL be 1 in every state other than FILL.
REQ-030 On the FILL edge, the block SHALL set resp_data to the captured data, set resp_hit=0, increment the victim pointer modulo WORDS (WORDS-1 wraps to 0) and go to RESP.
REQ-031 In RESP, resp_valid SHALL be 1 and resp_data and resp_hit SHALL be held stable until resp_ready=1; the block then returns to IDLE.
REQ-032 resp_valid and resp_ready both 1 in RESP SHALL make req_ready 1 in the next cycle; there is no same-cycle accept.
REQ-033 req_valid outside IDLE SHALL have no effect.
REQ-034 The victim pointer SHALL advance only on fills, never on hits.

Reset
REQ-035 While rst_=1 at an edge, the FSM SHALL go to IDLE and all outputs except cam_check_tag SHALL reset as follows:
- req_ready=1 in the next cycle.
- resp_valid=0, resp_data=0, resp_hit=0.
- mem_req=0, mem_tag=0.
- cam_write_=1, cam_w_addr=0, cam_wdata=0, cam_new_tag=0, cam_new_valid=0.
- The victim pointer and the registered tag are cleared, so cam_check_tag=0 from the next cycle.
REQ-036 Reset in any state, including MISS with mem_req=1 or FILL, SHALL abort the operation: no CAM write is issued, and a pending response is discarded.

Configuration
REQ-037 With CAM_FILL_STATS_EN defined, the block SHALL add outputs hit_cnt and miss_cnt, each 16 bits, cleared by reset and behaving as follows:
- hit_cnt increments on each LOOKUP hit edge.
- miss_cnt increments on each LOOKUP miss edge.
- Both saturate at 16'hFFFF.
REQ-038 Without CAM_FILL_STATS_EN, these ports and counters SHALL not exist, and all other behaviour is identical.

Verification
REQ-039 Cold miss: request tag 8'h3C; the memory returns 8'hA5 after a 3-cycle ack delay -> one cam_write_=0 pulse with cam_w_addr=0 and cam_new_tag=8'h3C, then resp_valid with resp_data=8'hA5 and resp_hit=0.
REQ-040 Hit: the CAM model holds tag 8'h3C with data 8'hA5; request 8'h3C -> resp_valid 2 cycles after acceptance with resp_data=8'hA5, resp_hit=1, mem_req never asserted, victim pointer unchanged.
REQ-041 Wrap: 9 misses to distinct tags -> cam_w_addr follows 0,1,...,7,0.
REQ-042 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_data and resp_hit stable, req_ready=0 throughout, and req_valid pulses are ignored.
REQ-043 Reset mid-miss: assert rst_ while mem_req=1, then ack -> no CAM write, resp_valid=0, req_ready=1 the cycle after reset deasserts.
REQ-044 Stats (with CAM_FILL_STATS_EN): 3 hits and 2 misses -> hit_cnt=3 and miss_cnt=2.
